// File: rtl/proj_switch_pkg.sv
// proj_switch_pkg: shared types and constants for the project switch controller.
// Holds the FSM state enum, isolate phase length and select-width helper.
package proj_switch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISOLATE,
    ST_RESET_HOLD,
    ST_RELEASE,
    ST_ACTIVE
  } state_e;

  localparam int ISOLATE_CYCLES = 2;

  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/proj_switch_timer.sv
// proj_switch_timer: loadable down-counter that stops at zero.
// Ports: clk, reset (async high), load_i/load_val_i, done_o (count is zero).
module proj_switch_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/proj_switch_ctrl.sv
// proj_switch_ctrl: sequences isolate / reset-hold / release when switching
// between user projects. Ports: clk, reset, sel_in/sel_off/sel_valid/sel_ready
// request handshake, active_sel, proj_reset, io_en, busy, err, wdt_kick,
// wdt_fired. Define PROJ_SWITCH_WDT_EN to build the ACTIVE-state watchdog.
module proj_switch_ctrl
  import proj_switch_pkg::*;
#(
  parameter int NUM_PROJECTS  = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int WDT_CYCLES    = 1048576,
  localparam int SEL_W = sel_w(NUM_PROJECTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    sel_off,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  output logic [SEL_W-1:0]        active_sel,
  output logic [NUM_PROJECTS-1:0] proj_reset,
  output logic                    io_en,
  output logic                    busy,
  output logic                    err,
  input  logic                    wdt_kick,
  output logic                    wdt_fired
);

  localparam int PW = $clog2(SETTLE_CYCLES + ISOLATE_CYCLES) + 1;
  localparam logic [PW-1:0] ISO_LD = PW'(ISOLATE_CYCLES - 1);
  localparam logic [PW-1:0] SET_LD = PW'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W:0] NP = (SEL_W + 1)'(NUM_PROJECTS);
  localparam logic [NUM_PROJECTS-1:0] ALL1 = '1;
  localparam logic [NUM_PROJECTS-1:0] ONE = NUM_PROJECTS'(1);

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d, tgt_q;
  logic                    off_q;
  logic [NUM_PROJECTS-1:0] prst_q, prst_d;
  logic                    io_q, busy_q, err_q;
  logic                    accept, invalid;
  logic                    ph_load, ph_done;
  logic [PW-1:0]           ph_val;
  logic                    wdt_to;

  assign sel_ready = ~reset &
    ((state_q == ST_IDLE) | (state_q == ST_ACTIVE));
  assign accept  = sel_valid & sel_ready;
  assign invalid = ~sel_off & ({1'b0, sel_in} >= NP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept & ~sel_off & ~invalid) state_d = ST_ISOLATE;
      end
      ST_ACTIVE: begin
        // any accepted request outranks a same-cycle timeout
        if (accept) begin
          if (~invalid) state_d = ST_ISOLATE;
        end else if (wdt_to) begin
          state_d = ST_RESET_HOLD;
        end
      end
      ST_ISOLATE: begin
        if (ph_done) state_d = ST_RESET_HOLD;
      end
      ST_RESET_HOLD: begin
        if (ph_done) state_d = off_q ? ST_IDLE : ST_RELEASE;
      end
      ST_RELEASE: begin
        if (ph_done) state_d = ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // new index is adopted only when a switch (not an off) enters reset-hold
  always_comb begin
    sel_d = sel_q;
    if (state_d == ST_RESET_HOLD && state_q == ST_ISOLATE && !off_q)
      sel_d = tgt_q;
  end

  always_comb begin
    prst_d = ALL1;
    case (state_d)
      ST_ACTIVE, ST_RELEASE: prst_d = ~(ONE << sel_d);
      ST_ISOLATE:            prst_d = prst_q;
      default:               prst_d = ALL1;
    endcase
  end

  assign ph_load = (state_d != state_q);
  assign ph_val  = (state_d == ST_ISOLATE) ? ISO_LD : SET_LD;

  proj_switch_timer #(.W(PW)) u_phase (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .done_o     (ph_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      tgt_q   <= '0;
      off_q   <= 1'b0;
      prst_q  <= ALL1;
      io_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prst_q  <= prst_d;
      io_q    <= (state_d == ST_ACTIVE);
      busy_q  <= (state_d == ST_ISOLATE) |
                 (state_d == ST_RESET_HOLD) |
                 (state_d == ST_RELEASE);
      err_q   <= accept & invalid;
      if (accept & ~invalid) begin
        tgt_q <= sel_in;
        off_q <= sel_off;
      end
    end
  end

`ifdef PROJ_SWITCH_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES) + 1;
  localparam logic [WW-1:0] WDT_LD = WW'(WDT_CYCLES - 1);

  logic wdt_load, wdt_done, fired_q;

  // held loaded outside ACTIVE so it restarts cleanly on entry
  assign wdt_load = wdt_kick | (state_q != ST_ACTIVE);
  assign wdt_to   = (state_q == ST_ACTIVE) & wdt_done & ~wdt_kick;

  proj_switch_timer #(.W(WW)) u_wdt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (wdt_load),
    .load_val_i (WDT_LD),
    .done_o     (wdt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fired_q <= 1'b0;
    end else begin
      fired_q <= (state_q == ST_ACTIVE) &
                 (state_d == ST_RESET_HOLD);
    end
  end

  assign wdt_fired = fired_q;
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick | WDT_CYCLES[0];
  assign wdt_to     = 1'b0;
  assign wdt_fired  = 1'b0;
`endif

  assign active_sel = sel_q;
  assign proj_reset = prst_q;
  assign io_en      = io_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_proj_switch_ctrl.sv
// tb_proj_switch_ctrl: directed bench for proj_switch_ctrl.
// Main instance N=8,S=4,W=64; a N=6 instance exercises out-of-range indices.
module tb_proj_switch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sel_in;
  logic       sel_off, sel_valid, sel_ready;
  logic [2:0] active_sel;
  logic [7:0] proj_reset;
  logic       io_en, busy, err, wdt_kick, wdt_fired;

  logic [2:0] sel_in6;
  logic       sel_off6, sel_valid6, sel_ready6;
  logic [2:0] active_sel6;
  logic [5:0] proj_reset6;
  logic       io_en6, busy6, err6, wdt_fired6;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  proj_switch_ctrl #(
    .NUM_PROJECTS (8),
    .SETTLE_CYCLES(4),
    .WDT_CYCLES   (64)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .sel_in     (sel_in),
    .sel_off    (sel_off),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .active_sel (active_sel),
    .proj_reset (proj_reset),
    .io_en      (io_en),
    .busy       (busy),
    .err        (err),
    .wdt_kick   (wdt_kick),
    .wdt_fired  (wdt_fired)
  );

  proj_switch_ctrl #(
    .NUM_PROJECTS (6),
    .SETTLE_CYCLES(4),
    .WDT_CYCLES   (64)
  ) u_dut6 (
    .clk        (clk),
    .reset      (reset),
    .sel_in     (sel_in6),
    .sel_off    (sel_off6),
    .sel_valid  (sel_valid6),
    .sel_ready  (sel_ready6),
    .active_sel (active_sel6),
    .proj_reset (proj_reset6),
    .io_en      (io_en6),
    .busy       (busy6),
    .err        (err6),
    .wdt_kick   (1'b0),
    .wdt_fired  (wdt_fired6)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // call right after the accepting edge; ends on the io_en rise
  task automatic run_switch(input logic [2:0] osel,
                            input logic [2:0] nsel,
                            input logic [7:0] opr,
                            input logic       poke);
    logic [7:0] epr;
    logic [7:0] npr;
    npr = ~(8'h01 << nsel);
    for (int k = 0; k <= 10; k++) begin
      epr = (k < 2) ? opr : (k < 6) ? 8'hFF : npr;
      chk($sformatf("prst k%0d", k), proj_reset, epr);
      chk($sformatf("io k%0d", k), io_en, k >= 10);
      chk($sformatf("busy k%0d", k), busy, k < 10);
      chk($sformatf("asel k%0d", k), active_sel,
          (k < 2) ? osel : nsel);
      if (poke && k == 3) begin
        sel_in    = 3'd1;
        sel_valid = 1'b1;
        chk("ready busy", sel_ready, 1'b0);
      end
      if (poke && k == 4) sel_valid = 1'b0;
      if (k < 10) tick();
    end
    chk("err sw", err, 1'b0);
  endtask

  task automatic request(input logic [2:0] s, input logic off);
    sel_in    = s;
    sel_off   = off;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    sel_off   = 1'b0;
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    sel_in = '0; sel_off = 0; sel_valid = 0; wdt_kick = 0;
    sel_in6 = '0; sel_off6 = 0; sel_valid6 = 0;
    repeat (2) tick();
    chk("rst ready", sel_ready, 1'b0);
    chk("rst prst", proj_reset, 8'hFF);
    chk("rst io", io_en, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst asel", active_sel, 3'd0);
    chk("rst wdt", wdt_fired, 1'b0);
    reset = 1'b0;
    #1;
    chk("ready idle", sel_ready, 1'b1);

    // out-of-range indices on the 6-project instance
    sel_in6 = 3'd6; sel_valid6 = 1'b1;
    tick();
    sel_valid6 = 1'b0;
    chk("err6 idle", err6, 1'b1);
    chk("busy6 idle", busy6, 1'b0);
    chk("prst6 idle", proj_reset6, 6'h3F);
    tick();
    chk("err6 pulse", err6, 1'b0);
    sel_in6 = 3'd2; sel_valid6 = 1'b1;
    tick();
    sel_valid6 = 1'b0;
    repeat (10) tick();
    chk("io6 act", io_en6, 1'b1);
    chk("prst6 act", proj_reset6, 6'h3B);
    sel_in6 = 3'd7; sel_valid6 = 1'b1;
    tick();
    sel_valid6 = 1'b0;
    chk("err6 act", err6, 1'b1);
    chk("io6 hold", io_en6, 1'b1);
    chk("prst6 hold", proj_reset6, 6'h3B);
    chk("asel6 hold", active_sel6, 3'd2);
    chk("busy6 hold", busy6, 1'b0);
    tick();
    chk("err6 end", err6, 1'b0);

    // IDLE -> 3, then 3 -> 5 with a request ignored while busy
    request(3'd3, 1'b0);
    run_switch(3'd0, 3'd3, 8'hFF, 1'b0);
    request(3'd5, 1'b0);
    run_switch(3'd3, 3'd5, 8'hF7, 1'b1);

    // deactivate from ACTIVE(5)
    request(3'd0, 1'b1);
    for (int k = 0; k <= 6; k++) begin
      chk($sformatf("off io k%0d", k), io_en, 1'b0);
      chk($sformatf("off busy k%0d", k), busy, k < 6);
      chk($sformatf("off prst k%0d", k), proj_reset,
          (k < 2) ? 8'hDF : 8'hFF);
      if (k < 6) tick();
    end
    chk("off asel", active_sel, 3'd5);
    chk("off ready", sel_ready, 1'b1);
    request(3'd2, 1'b1);
    chk("off idle busy", busy, 1'b0);
    chk("off idle prst", proj_reset, 8'hFF);

    // reset during RELEASE
    request(3'd1, 1'b0);
    repeat (7) tick();
    chk("rel prst", proj_reset, 8'hFD);
    chk("rel busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort prst", proj_reset, 8'hFF);
    chk("abort io", io_en, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort asel", active_sel, 3'd0);
    chk("abort ready", sel_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;

    // watchdog behaviour in ACTIVE(2)
    request(3'd2, 1'b0);
    run_switch(3'd0, 3'd2, 8'hFF, 1'b0);
`ifdef PROJ_SWITCH_WDT_EN
    seen = 1'b0;
    repeat (63) begin
      tick();
      seen |= wdt_fired;
    end
    chk("wdt early", seen, 1'b0);
    tick();
    chk("wdt fire", wdt_fired, 1'b1);
    chk("wdt io", io_en, 1'b0);
    chk("wdt prst", proj_reset, 8'hFF);
    chk("wdt asel", active_sel, 3'd2);
    tick();
    chk("wdt pulse", wdt_fired, 1'b0);
    repeat (6) tick();
    chk("wdt io low", io_en, 1'b0);
    tick();
    chk("wdt io back", io_en, 1'b1);
    chk("wdt prst back", proj_reset, 8'hFB);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      wdt_kick = (i % 32 == 0);
      tick();
      seen |= wdt_fired;
    end
    wdt_kick = 1'b0;
    chk("kick none", seen, 1'b0);
    chk("kick io", io_en, 1'b1);
`else
    seen = 1'b0;
    repeat (80) begin
      tick();
      seen |= wdt_fired;
    end
    chk("nowdt fire", seen, 1'b0);
    chk("nowdt io", io_en, 1'b1);
    chk("nowdt prst", proj_reset, 8'hFB);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
